// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM states, hazard priority,
// stall/flush bundle and the RUN-state evaluation used by hazard_ctrl.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // Listed from highest to lowest priority.
  typedef enum logic [2:0] {
    EV_MEM_WAIT,
    EV_MD_START,
    EV_BRANCH,
    EV_LOAD_USE,
    EV_NONE
  } hz_event_t;

  typedef struct packed {
    logic stallf;
    logic stalld;
    logic stalle;
    logic stallm;
    logic flushd;
    logic flushe;
    logic flushm;
    logic flushw;
  } hz_ctl_t;

  typedef struct packed {
    hz_ctl_t   ctl;
    hz_state_t nxt;
  } hz_eval_t;

  localparam hz_ctl_t CTL_NONE = hz_ctl_t'(8'b0000_0000);
  localparam hz_ctl_t CTL_LUSE = hz_ctl_t'(8'b1100_0100);
  localparam hz_ctl_t CTL_BR   = hz_ctl_t'(8'b0000_1100);
  localparam hz_ctl_t CTL_MD   = hz_ctl_t'(8'b1110_0010);
  localparam hz_ctl_t CTL_MEM  = hz_ctl_t'(8'b1111_0001);
  localparam hz_ctl_t CTL_RST  = hz_ctl_t'(8'b0000_1111);

  function automatic hz_event_t pick_event(input logic mem_wait, input logic md_start,
                                           input logic branch, input logic luse);
    if (mem_wait)      return EV_MEM_WAIT;
    else if (md_start) return EV_MD_START;
    else if (branch)   return EV_BRANCH;
    else if (luse)     return EV_LOAD_USE;
    else               return EV_NONE;
  endfunction

  function automatic hz_eval_t run_eval(input logic mem_wait, input logic md_start,
                                        input logic branch, input logic luse);
    hz_eval_t res;
    res.ctl = CTL_NONE;
    res.nxt = RUN;
    case (pick_event(mem_wait, md_start, branch, luse))
      EV_MEM_WAIT: begin res.ctl = CTL_MEM; res.nxt = MEM_WAIT; end
      EV_MD_START: begin res.ctl = CTL_MD;  res.nxt = MD_BUSY;  end
      EV_BRANCH:   res.ctl = CTL_BR;
      EV_LOAD_USE: res.ctl = CTL_LUSE;
      default:     res.ctl = CTL_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hazard_ctrl_cnt.sv
// Saturating stall-cycle counter; holds at all-ones instead of wrapping.
module hazard_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)                        r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, mul/div and memory-wait stalls plus
// branch flushes, with zero-latency outputs derived from state and inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rde,
  input  logic             mem_rde,
  input  logic             branch_e,
  input  logic             md_start_e,
  input  logic             md_done,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             flushd,
  output logic             flushe,
  output logic             flushm,
  output logic             flushw,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_t r_state;
  hz_eval_t  w_res;
  logic      w_luse;
  logic      w_mem_wait;

  assign w_luse     = mem_rde && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));
  assign w_mem_wait = dmem_req_m && !dmem_ready;

  // NOTE: w_res gets a full default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_res.ctl = CTL_NONE;
    w_res.nxt = RUN;
    case (r_state)
      RUN:      w_res = run_eval(w_mem_wait, md_start_e, branch_e, w_luse);
      MD_BUSY: begin
        if (md_done) begin
          w_res = run_eval(w_mem_wait, 1'b0, branch_e, w_luse);
        end else begin
          w_res.ctl = CTL_MD;
          w_res.nxt = MD_BUSY;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_res = run_eval(1'b0, md_start_e, branch_e, w_luse);
        end else begin
          w_res.ctl = CTL_MEM;
          w_res.nxt = MEM_WAIT;
        end
      end
      default:  w_res = run_eval(w_mem_wait, md_start_e, branch_e, w_luse);
    endcase
    // Reset bubbles every stage and aborts any pending wait.
    if (rst) begin
      w_res.ctl = CTL_RST;
      w_res.nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_res.nxt;
  end

  assign stallf = w_res.ctl.stallf;
  assign stalld = w_res.ctl.stalld;
  assign stalle = w_res.ctl.stalle;
  assign stallm = w_res.ctl.stallm;
  assign flushd = w_res.ctl.flushd;
  assign flushe = w_res.ctl.flushe;
  assign flushm = w_res.ctl.flushm;
  assign flushw = w_res.ctl.flushw;

  hazard_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_res.ctl.stallf),
    .o_cnt (stall_cnt)
  );

endmodule
